// File: rtl/core_bus_arbiter_if.sv
// Avalon-MM bus bundle with pipelined reads. The slave modport is the view of
// the module that answers the bus; the master modport is the view of the one that issues commands.
interface i_avl_bus;
   logic [31:0] address;
   logic [3:0]  byte_en;
   logic        read;
   logic        write;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        read_data_valid;
   logic        wait_request;

   modport master (
      output address, byte_en, read, write, write_data,
      input  read_data, read_data_valid, wait_request
   );

   modport slave (
      input  address, byte_en, read, write, write_data,
      output read_data, read_data_valid, wait_request
   );
endinterface

// File: rtl/core_bus_arbiter.sv
// Two-requester Avalon arbiter: combinational command forwarding, a grant lock
// across stalls, and an ID FIFO that routes pipelined read responses in issue order.
module core_bus_arbiter #(
   parameter int MAX_PENDING = 4,
   parameter int FIXED_PRIO  = 0
) (
   input  logic     clk,
   input  logic     rest,
   i_avl_bus.slave  avl_s0,
   i_avl_bus.slave  avl_s1,
   i_avl_bus.master avl_m,
   output logic     rsp_err
);

   localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t      state, state_nxt;
   logic             lock_id, lock_id_nxt;
   logic             last_id;
   logic [CNT_W-1:0] cnt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             id_mem [MAX_PENDING];

   logic        full, elig0, elig1;
   logic        gnt_vld, gnt_id;
   logic [31:0] sel_addr, sel_wdata;
   logic [3:0]  sel_be;
   logic        sel_rd, sel_wr;
   logic        fwd_rd, xfer, push, pop, orphan, head_id;

   // A read is not eligible while the FIFO is full, so it can neither win nor lock.
   always_comb begin
      full  = (cnt == FULL_CNT);
      elig0 = avl_s0.write | (avl_s0.read & ~full);
      elig1 = avl_s1.write | (avl_s1.read & ~full);
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (!rest) begin
         if (state == LOCKED && (lock_id ? elig1 : elig0)) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id;
         end else if (elig0 && elig1) begin
            gnt_vld = 1'b1;
            gnt_id  = (FIXED_PRIO != 0) ? 1'b1 : ~last_id;
         end else if (elig0) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
         end else if (elig1) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr  = gnt_id ? avl_s1.address    : avl_s0.address;
      sel_be    = gnt_id ? avl_s1.byte_en    : avl_s0.byte_en;
      sel_rd    = gnt_id ? avl_s1.read       : avl_s0.read;
      sel_wr    = gnt_id ? avl_s1.write      : avl_s0.write;
      sel_wdata = gnt_id ? avl_s1.write_data : avl_s0.write_data;
      fwd_rd    = gnt_vld & sel_rd & ~full;
   end

   always_comb begin
      avl_m.address    = gnt_vld ? sel_addr  : '0;
      avl_m.byte_en    = gnt_vld ? sel_be    : '0;
      avl_m.read       = fwd_rd;
      avl_m.write      = gnt_vld & sel_wr;
      avl_m.write_data = gnt_vld ? sel_wdata : '0;
   end

   always_comb begin
      xfer    = gnt_vld & ~avl_m.wait_request;
      push    = xfer & fwd_rd;
      pop     = avl_m.read_data_valid & (cnt != '0);
      orphan  = avl_m.read_data_valid & (cnt == '0);
      head_id = id_mem[rd_ptr];
   end

   // Response side: data is broadcast, valid goes only to the owner of the head ID.
   always_comb begin
      avl_s0.read_data       = avl_m.read_data;
      avl_s1.read_data       = avl_m.read_data;
      avl_s0.read_data_valid = pop & ~head_id;
      avl_s1.read_data_valid = pop & head_id;
      avl_s0.wait_request    = rest | ~(gnt_vld & ~gnt_id) | avl_m.wait_request;
      avl_s1.wait_request    = rest | ~(gnt_vld & gnt_id) | avl_m.wait_request;
   end

   always_comb begin
      state_nxt   = UNLOCKED;
      lock_id_nxt = lock_id;
      if (gnt_vld && avl_m.wait_request) begin
         state_nxt   = LOCKED;
         lock_id_nxt = gnt_id;
      end
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state   <= UNLOCKED;
         lock_id <= 1'b0;
         last_id <= 1'b1;
      end else begin
         state   <= state_nxt;
         lock_id <= lock_id_nxt;
         if (xfer) last_id <= gnt_id;
      end
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         cnt     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (orphan) rsp_err <= 1'b1;
      end
   end

   // ID storage is pure data; validity is carried by cnt and the pointers.
   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr] <= gnt_id;
   end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed-vector bench for core_bus_arbiter: a round-robin instance and a
// fixed-priority instance, driven on the falling edge and checked 1 ns later.
module tb_core_bus_arbiter;
   logic clk  = 1'b0;
   logic rest = 1'b1;
   logic err0, err1;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   i_avl_bus s0 ();
   i_avl_bus s1 ();
   i_avl_bus m ();
   i_avl_bus p0 ();
   i_avl_bus p1 ();
   i_avl_bus pm ();

   core_bus_arbiter #(.MAX_PENDING(4), .FIXED_PRIO(0)) dut (
      .clk(clk), .rest(rest), .avl_s0(s0), .avl_s1(s1), .avl_m(m), .rsp_err(err0)
   );

   core_bus_arbiter #(.MAX_PENDING(4), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rest(rest), .avl_s0(p0), .avl_s1(p1), .avl_m(pm), .rsp_err(err1)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1);
   end

   task automatic clr();
      s0.read = 0; s0.write = 0; s0.address = 0; s0.byte_en = 4'hF; s0.write_data = 0;
      s1.read = 0; s1.write = 0; s1.address = 0; s1.byte_en = 4'hF; s1.write_data = 0;
      p0.read = 0; p0.write = 0; p0.address = 0; p0.byte_en = 4'hF; p0.write_data = 0;
      p1.read = 0; p1.write = 0; p1.address = 0; p1.byte_en = 4'hF; p1.write_data = 0;
      m.wait_request = 0; m.read_data = 0; m.read_data_valid = 0;
      pm.wait_request = 0; pm.read_data = 0; pm.read_data_valid = 0;
   endtask

   task automatic test_reset();
      clr();
      s0.read = 1; s0.address = 32'h100; s1.write = 1; m.read_data_valid = 1;
      @(negedge clk); #1;
      vecs++; if (m.read !== 1'b0) begin errs++; $display("FAIL rst_m_read got %b want 0", m.read); end
      vecs++; if (m.write !== 1'b0) begin errs++; $display("FAIL rst_m_write got %b want 0", m.write); end
      vecs++; if (m.address !== 32'h0) begin errs++; $display("FAIL rst_m_addr got %h want 0", m.address); end
      vecs++; if (s0.wait_request !== 1'b1) begin errs++; $display("FAIL rst_s0_wait got %b want 1", s0.wait_request); end
      vecs++; if (s1.wait_request !== 1'b1) begin errs++; $display("FAIL rst_s1_wait got %b want 1", s1.wait_request); end
      vecs++; if (s0.read_data_valid !== 1'b0) begin errs++; $display("FAIL rst_s0_rdv got %b want 0", s0.read_data_valid); end
      vecs++; if (s1.read_data_valid !== 1'b0) begin errs++; $display("FAIL rst_s1_rdv got %b want 0", s1.read_data_valid); end
      vecs++; if (err0 !== 1'b0) begin errs++; $display("FAIL rst_rsp_err got %b want 0", err0); end
      @(negedge clk);
      clr();
      rest = 0;
      #1;
      vecs++; if (m.read !== 1'b0) begin errs++; $display("FAIL idle_m_read got %b want 0", m.read); end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr;
      @(negedge clk);
      s0.read = 1; s0.address = 32'h100;
      s1.read = 1; s1.address = 32'h200;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
         vecs++; if (m.address !== exp_addr) begin errs++; $display("FAIL rr_addr c%0d got %h want %h", i, m.address, exp_addr); end
         vecs++; if (m.read !== 1'b1) begin errs++; $display("FAIL rr_read c%0d got %b want 1", i, m.read); end
         vecs++; if (s0.wait_request !== (i % 2 != 0)) begin errs++; $display("FAIL rr_s0_wait c%0d got %b want %b", i, s0.wait_request, (i % 2 != 0)); end
         vecs++; if (s1.wait_request !== (i % 2 == 0)) begin errs++; $display("FAIL rr_s1_wait c%0d got %b want %b", i, s1.wait_request, (i % 2 == 0)); end
         @(negedge clk);
      end
      s0.read = 0; s1.read = 0;
      for (int i = 0; i < 4; i++) begin
         m.read_data_valid = 1; m.read_data = 32'h10 + i;
         #1;
         vecs++; if (s0.read_data_valid !== (i % 2 == 0)) begin errs++; $display("FAIL rr_s0_rdv r%0d got %b want %b", i, s0.read_data_valid, (i % 2 == 0)); end
         vecs++; if (s1.read_data_valid !== (i % 2 != 0)) begin errs++; $display("FAIL rr_s1_rdv r%0d got %b want %b", i, s1.read_data_valid, (i % 2 != 0)); end
         vecs++; if (s1.read_data !== 32'h10 + i) begin errs++; $display("FAIL rr_bcast r%0d got %h want %h", i, s1.read_data, 32'h10 + i); end
         @(negedge clk);
      end
      m.read_data_valid = 0;
   endtask

   task automatic test_lock();
      s0.write = 1; s0.address = 32'h4;
      #1;
      vecs++; if (s0.wait_request !== 1'b0) begin errs++; $display("FAIL lk_pre_s0_wait got %b want 0", s0.wait_request); end
      @(negedge clk);
      clr();
      s1.write = 1; s1.address = 32'h8; s1.write_data = 32'hDEADBEEF;
      s0.read = 1; s0.address = 32'h40;
      for (int i = 0; i < 4; i++) begin
         m.wait_request = (i < 3);
         #1;
         vecs++; if (m.write !== 1'b1 || m.address !== 32'h8) begin errs++; $display("FAIL lk_cmd c%0d got w=%b a=%h want w=1 a=8", i, m.write, m.address); end
         vecs++; if (m.write_data !== 32'hDEADBEEF) begin errs++; $display("FAIL lk_wdata c%0d got %h want deadbeef", i, m.write_data); end
         vecs++; if (s0.wait_request !== 1'b1) begin errs++; $display("FAIL lk_s0_wait c%0d got %b want 1", i, s0.wait_request); end
         vecs++; if (s1.wait_request !== (i < 3)) begin errs++; $display("FAIL lk_s1_wait c%0d got %b want %b", i, s1.wait_request, (i < 3)); end
         @(negedge clk);
      end
      s1.write = 0; m.wait_request = 0;
      #1;
      vecs++; if (m.read !== 1'b1 || m.address !== 32'h40) begin errs++; $display("FAIL lk_c5_cmd got r=%b a=%h want r=1 a=40", m.read, m.address); end
      vecs++; if (s0.wait_request !== 1'b0) begin errs++; $display("FAIL lk_c5_s0_wait got %b want 0", s0.wait_request); end
      @(negedge clk);
      s0.read = 0; m.read_data_valid = 1; m.read_data = 32'h55;
      #1;
      vecs++; if (s0.read_data_valid !== 1'b1 || s1.read_data_valid !== 1'b0) begin errs++; $display("FAIL lk_rsp got s0=%b s1=%b want s0=1 s1=0", s0.read_data_valid, s1.read_data_valid); end
      @(negedge clk);
      m.read_data_valid = 0;
   endtask

   task automatic test_lock_hold();
      s1.write = 1; s1.address = 32'hC;
      #1;
      vecs++; if (s1.wait_request !== 1'b0) begin errs++; $display("FAIL lh_pre_s1_wait got %b want 0", s1.wait_request); end
      @(negedge clk);
      s1.address = 32'h10; m.wait_request = 1;
      #1;
      vecs++; if (m.address !== 32'h10 || m.write !== 1'b1) begin errs++; $display("FAIL lh_stall got w=%b a=%h want w=1 a=10", m.write, m.address); end
      @(negedge clk);
      s0.write = 1; s0.address = 32'h20; m.wait_request = 0;
      #1;
      vecs++; if (m.address !== 32'h10) begin errs++; $display("FAIL lh_held_addr got %h want 10", m.address); end
      vecs++; if (s0.wait_request !== 1'b1 || s1.wait_request !== 1'b0) begin errs++; $display("FAIL lh_held_wait got s0=%b s1=%b want s0=1 s1=0", s0.wait_request, s1.wait_request); end
      @(negedge clk);
      s1.write = 0;
      #1;
      vecs++; if (m.address !== 32'h20 || s0.wait_request !== 1'b0) begin errs++; $display("FAIL lh_after got a=%h w0=%b want a=20 w0=0", m.address, s0.wait_request); end
      @(negedge clk);
      clr();
   endtask

   task automatic test_fifo_full();
      logic [31:0] dat [5];
      logic        own [5];
      dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      own = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         clr();
         if (i % 2 == 0) begin s0.read = 1; s0.address = 32'h300 + 4 * i; end
         else begin s1.read = 1; s1.address = 32'h300 + 4 * i; end
         #1;
         vecs++; if (m.read !== 1'b1 || m.address !== 32'h300 + 4 * i) begin errs++; $display("FAIL ff_issue c%0d got r=%b a=%h want r=1 a=%h", i, m.read, m.address, 32'h300 + 4 * i); end
         @(negedge clk);
      end
      clr();
      s0.read = 1; s0.address = 32'h500;
      #1;
      vecs++; if (m.read !== 1'b0 || s0.wait_request !== 1'b1) begin errs++; $display("FAIL ff_block got r=%b w0=%b want r=0 w0=1", m.read, s0.wait_request); end
      @(negedge clk);
      s1.write = 1; s1.address = 32'h600;
      #1;
      vecs++; if (m.write !== 1'b1 || m.address !== 32'h600) begin errs++; $display("FAIL ff_wr_pass got w=%b a=%h want w=1 a=600", m.write, m.address); end
      vecs++; if (s1.wait_request !== 1'b0 || s0.wait_request !== 1'b1) begin errs++; $display("FAIL ff_wr_wait got w1=%b w0=%b want w1=0 w0=1", s1.wait_request, s0.wait_request); end
      @(negedge clk);
      s1.write = 0;
      for (int i = 0; i < 5; i++) begin
         m.read_data_valid = 1; m.read_data = dat[i];
         if (i == 2) s0.read = 0;
         #1;
         vecs++; if (s0.read_data_valid !== ~own[i] || s1.read_data_valid !== own[i]) begin errs++; $display("FAIL ff_route r%0d got s0=%b s1=%b want owner s%0d", i, s0.read_data_valid, s1.read_data_valid, own[i]); end
         vecs++; if (s0.read_data !== dat[i]) begin errs++; $display("FAIL ff_data r%0d got %h want %h", i, s0.read_data, dat[i]); end
         if (i == 0) begin
            vecs++; if (m.read !== 1'b0 || s0.wait_request !== 1'b1) begin errs++; $display("FAIL ff_same_pop got r=%b w0=%b want r=0 w0=1", m.read, s0.wait_request); end
         end
         if (i == 1) begin
            vecs++; if (m.read !== 1'b1 || m.address !== 32'h500 || s0.wait_request !== 1'b0) begin errs++; $display("FAIL ff_unblock got r=%b a=%h w0=%b want r=1 a=500 w0=0", m.read, m.address, s0.wait_request); end
         end
         @(negedge clk);
      end
      m.read_data_valid = 0;
   endtask

   task automatic test_orphan();
      m.read_data_valid = 1; m.read_data = 32'h77;
      #1;
      vecs++; if (s0.read_data_valid !== 1'b0 || s1.read_data_valid !== 1'b0) begin errs++; $display("FAIL or_drop got s0=%b s1=%b want 0 0", s0.read_data_valid, s1.read_data_valid); end
      vecs++; if (err0 !== 1'b0) begin errs++; $display("FAIL or_pre_err got %b want 0", err0); end
      @(negedge clk);
      m.read_data_valid = 0;
      #1;
      vecs++; if (err0 !== 1'b1) begin errs++; $display("FAIL or_set got %b want 1", err0); end
      @(negedge clk); #1;
      vecs++; if (err0 !== 1'b1) begin errs++; $display("FAIL or_sticky got %b want 1", err0); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      s0.read = 1; s0.address = 32'h700;
      @(negedge clk);
      s0.read = 0; s1.read = 1; s1.address = 32'h704;
      @(negedge clk);
      s1.read = 0; s0.read = 1;
      #2 rest = 1;
      #1;
      vecs++; if (err0 !== 1'b0) begin errs++; $display("FAIL rm_err_clr got %b want 0", err0); end
      vecs++; if (m.read !== 1'b0 || s0.wait_request !== 1'b1 || s1.wait_request !== 1'b1) begin errs++; $display("FAIL rm_outs got r=%b w0=%b w1=%b want 0 1 1", m.read, s0.wait_request, s1.wait_request); end
      s0.read = 0;
      #1 rest = 0;
      @(negedge clk);
      m.read_data_valid = 1; m.read_data = 32'h99;
      #1;
      vecs++; if (s0.read_data_valid !== 1'b0 || s1.read_data_valid !== 1'b0) begin errs++; $display("FAIL rm_drop got s0=%b s1=%b want 0 0", s0.read_data_valid, s1.read_data_valid); end
      @(negedge clk);
      m.read_data_valid = 0;
      #1;
      vecs++; if (err0 !== 1'b1) begin errs++; $display("FAIL rm_err_set got %b want 1", err0); end
      @(negedge clk);
   endtask

   task automatic test_fixed_prio();
      p0.read = 1; p0.address = 32'h900;
      p1.read = 1; p1.address = 32'hA00;
      for (int i = 0; i < 6; i++) begin
         pm.read_data_valid = (i > 0); pm.read_data = i;
         #1;
         vecs++; if (pm.address !== 32'hA00 || pm.read !== 1'b1) begin errs++; $display("FAIL fp_gnt c%0d got r=%b a=%h want r=1 a=a00", i, pm.read, pm.address); end
         vecs++; if (p0.wait_request !== 1'b1 || p1.wait_request !== 1'b0) begin errs++; $display("FAIL fp_wait c%0d got w0=%b w1=%b want 1 0", i, p0.wait_request, p1.wait_request); end
         vecs++; if (p1.read_data_valid !== (i > 0) || p0.read_data_valid !== 1'b0) begin errs++; $display("FAIL fp_rdv c%0d got v0=%b v1=%b want 0 %b", i, p0.read_data_valid, p1.read_data_valid, (i > 0)); end
         @(negedge clk);
      end
      clr();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_lock();
      test_lock_hold();
      test_fifo_full();
      test_orphan();
      test_reset_mid();
      test_fixed_prio();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameter MAX_PENDING, default 4: depth of the outstanding-read ID FIFO; SHALL be a power of two, 2..16.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 gives fixed priority to avl_s1.
REQ-003 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port rest, input, 1: reset, asynchronous and active-high.
REQ-005 Port avl_s0, i_avl_bus.slave, -: the instruction-fetch requester (ID 0).
REQ-006 Port avl_s1, i_avl_bus.slave, -: the data requester (ID 1).
REQ-007 Port avl_m, i_avl_bus.master, -: the shared memory port.
REQ-008 Port rsp_err, output, 1: sticky flag, set on a read_data_valid with no read outstanding.
REQ-009 Each i_avl_bus SHALL carry address[31:0], byte_en[3:0], read, write, write_data[31:0], read_data[31:0], read_data_valid, wait_request, with pipelined-read Avalon semantics.

Function
REQ-010 A requester SHALL be active when its read or write is high; a command transfers when it is forwarded to avl_m and avl_m.wait_request=0.
REQ-011 Commands SHALL be forwarded combinationally, with zero added latency: avl_m address, byte_en, read, write and write_data equal those of the granted requester, or all zero when none is granted.
REQ-012 Any non-granted active requester SHALL see wait_request=1.
REQ-013 Arbitration with FIXED_PRIO=0: when both are active and grant is unlocked, the requester not served by the last transfer (last_id) wins; with a single active requester, that requester wins.
REQ-014 Arbitration with FIXED_PRIO=1: avl_s1 wins every tie; last_id is still tracked.
REQ-015 Lock: if the granted command sees avl_m.wait_request=1, the grant SHALL be held, unchanged, for the next cycle. It releases only on the transfer cycle, or when the requester deasserts read/write.
REQ-016 Read ID FIFO: each accepted read pushes the granted ID, and cnt increments. Each avl_m.read_data_valid pops the head ID, and cnt decrements. Push and pop in the same cycle leave cnt unchanged.
REQ-017 When cnt==MAX_PENDING, no read SHALL be forwarded: read requesters see wait_request=1, and a blocked read does not lock the grant. Writes still arbitrate normally. The full check uses the registered cnt, so a same-cycle pop does not unblock a read.
REQ-018 Response routing: avl_m.read_data SHALL be broadcast to both slaves. read_data_valid SHALL be asserted only on the slave whose ID is at the FIFO head, in the same cycle as avl_m.read_data_valid.
REQ-019 A read_data_valid with cnt==0 SHALL be dropped: neither slave sees valid, the FIFO is unchanged, and rsp_err is set to 1 until reset.
REQ-020 Responses SHALL return to requesters in issue order; no reordering.
REQ-021 Writes SHALL not touch the FIFO. A write transfer SHALL update last_id.
REQ-022 A requester changing its command while stalled is a protocol violation; the arbiter need not detect it.

Reset
REQ-023 On rest=1, regardless of clk: FIFO empty, cnt=0, grant unlocked, last_id=1 (so avl_s0 wins the first tie), rsp_err=0.
REQ-024 Reset mid-operation SHALL discard outstanding read IDs. Responses arriving after reset are treated per REQ-019.
REQ-025 During reset, all avl_m command outputs and both slaves' read_data_valid SHALL be 0, and both slaves' wait_request SHALL be 1.

Verification
REQ-026 Both slaves read at once (s0 addr 0x100, s1 addr 0x200), wait_request=0, FIXED_PRIO=0 -> s0 transfers in cycle 1, s1 in cycle 2, then alternate.
REQ-027 s1 write 0x8 = 0xDEADBEEF with avl_m.wait_request=1 for 3 cycles while s0 reads -> s1 holds the grant all 4 cycles; s0 sees wait_request=1 until cycle 5.
REQ-028 Issue 4 reads (s0, s1, s0, s1) with no responses -> cnt=4, and a 5th s0 read stalls. Return 4 read_data_valid with data 0x11, 0x22, 0x33, 0x44 -> delivered to s0, s1, s0, s1 in order; the 5th read is forwarded only after the first pop.
REQ-029 avl_m.read_data_valid=1 with cnt=0 -> no slave valid, rsp_err=1 on the next edge and staying 1.
REQ-030 Two reads outstanding, rest pulsed 1 mid-cycle -> cnt=0 and rsp_err=0 immediately. The first later response sets rsp_err=1.
REQ-031 FIXED_PRIO=1, both requesting reads every cycle -> s1 is granted every cycle and s0 is starved.
